// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: hazard, stall, flush and forwarding sequencer for a 5-stage RV32I pipeline.
// Tracks destination tags of the instructions in EX, MEM and WB. From those tags it drives the
// pipeline-register enables and flushes, and the EX operand forwarding selects.
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   id_*                  decoded fields of the instruction in ID (valid, sources, dest, rf/mem ctl)
//   ex_redirect           EX instruction is a taken branch / JAL / JALR
//   dmem_ready            data memory completes the MEM-stage access this cycle
//   pc_en .. ex_mem_en    pipeline register load enables
//   *_flush               load a bubble into the named pipeline register
//   fwd_a_sel, fwd_b_sel  EX operand source: 00 RF, 01 EX/MEM, 10 MEM/WB
//   stalled               any stall condition active this cycle
// Build option: define FORWARDING_EN to enable forwarding; only load-use then stalls.
// Without it, any dependency on EX/MEM/WB stalls and both selects stay 00.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic                      id_uses_rs1,
  input  logic                      id_uses_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic                      id_rf_write,
  input  logic                      id_mem_read,
  input  logic                      id_mem_write,
  input  logic                      ex_redirect,
  input  logic                      dmem_ready,
  output logic                      pc_en,
  output logic                      if_id_en,
  output logic                      id_ex_en,
  output logic                      ex_mem_en,
  output logic                      if_id_flush,
  output logic                      id_ex_flush,
  output logic                      mem_wb_flush,
  output logic [1:0]                fwd_a_sel,
  output logic [1:0]                fwd_b_sel,
  output logic                      stalled
);
`ifdef FORWARDING_EN
  localparam logic FWD = 1'b1;
`else
  localparam logic FWD = 1'b0;
`endif
  typedef enum logic [1:0] {BOOT, RUN, MEM_WAIT} state_t;
  typedef struct packed {
    logic                      valid;
    logic [REG_ADDR_WIDTH-1:0] rd, rs1, rs2;
    logic                      uses_rs1, uses_rs2, rf_write, mem_read, mem_access;
  } ex_tag_t;
  typedef struct packed {
    logic                      valid;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      rf_write, mem_read, mem_access;
  } mem_tag_t;
  typedef struct packed {
    logic                      valid;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      rf_write;
  } wb_tag_t;
  state_t   state;
  ex_tag_t  ex_tag;
  mem_tag_t mem_tag;
  wb_tag_t  wb_tag;
  logic boot, mem_stall, redirect, hazard, hold;
  function automatic logic hit(input logic v, w, input logic [REG_ADDR_WIDTH-1:0] rd, src);
    return v & w & (rd != '0) & (rd == src);
  endfunction
  // Producers an ID source must wait for: only an in-flight load when forwarding, else any writer.
  function automatic logic dep(input logic [REG_ADDR_WIDTH-1:0] src);
    return FWD ? hit(ex_tag.valid & ex_tag.mem_read, ex_tag.rf_write, ex_tag.rd, src)
               : hit(ex_tag.valid, ex_tag.rf_write, ex_tag.rd, src)
               | hit(mem_tag.valid, mem_tag.rf_write, mem_tag.rd, src)
               | hit(wb_tag.valid, wb_tag.rf_write, wb_tag.rd, src);
  endfunction
  // A load in MEM has no data yet, so it never forwards from EX/MEM.
  function automatic logic [1:0] sel(input logic [REG_ADDR_WIDTH-1:0] src, input logic uses);
    return !(FWD & ex_tag.valid & uses) ? 2'b00
         : hit(mem_tag.valid & ~mem_tag.mem_read, mem_tag.rf_write, mem_tag.rd, src) ? 2'b01
         : hit(wb_tag.valid, wb_tag.rf_write, wb_tag.rd, src) ? 2'b10 : 2'b00;
  endfunction
  always_comb begin
    boot         = state == BOOT;
    mem_stall    = mem_tag.valid & mem_tag.mem_access & ~dmem_ready;
    redirect     = ex_redirect & ex_tag.valid & ~mem_stall;
    hazard       = id_valid & ((id_uses_rs1 & dep(id_rs1)) | (id_uses_rs2 & dep(id_rs2)));
    hold         = hazard & ~redirect;
    pc_en        = ~boot & ~mem_stall & ~hold;
    if_id_en     = ~boot & ~mem_stall & ~hold;
    id_ex_en     = ~boot & ~mem_stall;
    ex_mem_en    = ~boot & ~mem_stall;
    if_id_flush  = boot | redirect;
    id_ex_flush  = boot | redirect | (hold & ~mem_stall);
    mem_wb_flush = boot | mem_stall;
    fwd_a_sel    = sel(ex_tag.rs1, ex_tag.uses_rs1);
    fwd_b_sel    = sel(ex_tag.rs2, ex_tag.uses_rs2);
    stalled      = boot | mem_stall | hold;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= BOOT;
      ex_tag  <= '0;
      mem_tag <= '0;
      wb_tag  <= '0;
    end else if (boot) begin
      state <= RUN;
    end else begin
      state  <= mem_stall ? MEM_WAIT : RUN;
      wb_tag <= mem_stall ? '0 : '{valid: mem_tag.valid, rd: mem_tag.rd, rf_write: mem_tag.rf_write};
      if (!mem_stall) begin
        mem_tag <= '{valid: ex_tag.valid, rd: ex_tag.rd, rf_write: ex_tag.rf_write,
                     mem_read: ex_tag.mem_read, mem_access: ex_tag.mem_access};
        ex_tag  <= (redirect | hazard | ~id_valid) ? '0
                 : '{valid: 1'b1, rd: id_rd, rs1: id_rs1, rs2: id_rs2, uses_rs1: id_uses_rs1,
                     uses_rs2: id_uses_rs2, rf_write: id_rf_write, mem_read: id_mem_read,
                     mem_access: id_mem_read | id_mem_write};
      end
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: randomized check of pipeline_hazard_ctrl against an instruction-level model
module tb_pipeline_hazard_ctrl;
  logic clk = 0, rst = 1;
  logic id_valid = 0, id_uses_rs1 = 0, id_uses_rs2 = 0, id_rf_write = 0, id_mem_read = 0, id_mem_write = 0;
  logic [4:0] id_rs1 = 0, id_rs2 = 0, id_rd = 0;
  logic ex_redirect = 0, dmem_ready = 0;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, mem_wb_flush, stalled;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  int n_checks = 0, n_errors = 0;
  pipeline_hazard_ctrl #(.REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd), .id_rf_write(id_rf_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .ex_redirect(ex_redirect),
    .dmem_ready(dmem_ready), .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .mem_wb_flush(mem_wb_flush), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stalled(stalled)
  );
  always #5 clk = ~clk;
  // Whole instructions flow through the model pipeline; each stage slot is one instruction.
  typedef struct {
    bit v;
    int rd, rs1, rs2;
    bit u1, u2, wr, ld, acc;
  } ins_t;
  ins_t nil, ex_i, mem_i, wb_i;
  bit boot, m_stall, m_redir, m_haz;
  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask
  function automatic bit writes(ins_t i, int s);
    return i.v && i.wr && i.rd != 0 && i.rd == s;
  endfunction
  function automatic bit waits_on(int s);
`ifdef FORWARDING_EN
    return writes(ex_i, s) && ex_i.ld;
`else
    return writes(ex_i, s) || writes(mem_i, s) || writes(wb_i, s);
`endif
  endfunction
  function automatic int fwd(int s, bit u);
`ifdef FORWARDING_EN
    if (!ex_i.v || !u) return 0;
    if (writes(mem_i, s) && !mem_i.ld) return 1;
    if (writes(wb_i, s)) return 2;
`endif
    return 0;
  endfunction
  task automatic evaluate();
    logic [6:0] e;
    m_stall = mem_i.v && mem_i.acc && !dmem_ready;
    m_redir = ex_redirect && ex_i.v && !m_stall;
    m_haz = id_valid && ((id_uses_rs1 && waits_on(id_rs1)) || (id_uses_rs2 && waits_on(id_rs2)));
    // {pc, if_id, id_ex, ex_mem enables, if_id, id_ex, mem_wb flushes} in priority order
    if (boot) e = 7'b0000_111;
    else if (m_stall) e = 7'b0000_001;
    else if (m_redir) e = 7'b1111_110;
    else if (m_haz) e = 7'b0011_010;
    else e = 7'b1111_000;
    check("pc_en", pc_en, e[6]);
    check("if_id_en", if_id_en, e[5]);
    check("id_ex_en", id_ex_en, e[4]);
    check("ex_mem_en", ex_mem_en, e[3]);
    check("if_id_flush", if_id_flush, e[2]);
    check("id_ex_flush", id_ex_flush, e[1]);
    check("mem_wb_flush", mem_wb_flush, e[0]);
    check("fwd_a_sel", fwd_a_sel, 4'(fwd(ex_i.rs1, ex_i.u1)));
    check("fwd_b_sel", fwd_b_sel, 4'(fwd(ex_i.rs2, ex_i.u2)));
    check("stalled", stalled, boot || m_stall || (m_haz && !m_redir));
  endtask
  task automatic advance();
    if (boot) boot = 0;
    else if (m_stall) wb_i = nil;
    else begin
      wb_i = mem_i;
      mem_i = ex_i;
      ex_i = (m_redir || m_haz || !id_valid) ? nil
           : '{1, int'(id_rd), int'(id_rs1), int'(id_rs2), id_uses_rs1, id_uses_rs2,
               id_rf_write, id_mem_read, id_mem_read | id_mem_write};
    end
  endtask
  initial begin
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst = (i < 2) || ($urandom_range(0, 199) == 0);
      if (rst) begin
        boot = 1;
        ex_i = nil;
        mem_i = nil;
        wb_i = nil;
      end
      id_valid     = $urandom_range(0, 99) < 85;
      id_rs1       = 5'($urandom_range(0, 3));
      id_rs2       = 5'($urandom_range(0, 3));
      id_rd        = 5'($urandom_range(0, 3));
      id_uses_rs1  = $urandom_range(0, 99) < 80;
      id_uses_rs2  = $urandom_range(0, 99) < 60;
      id_rf_write  = $urandom_range(0, 99) < 70;
      id_mem_read  = $urandom_range(0, 99) < 25;
      id_mem_write = !id_mem_read && $urandom_range(0, 99) < 20;
      ex_redirect  = $urandom_range(0, 99) < 15;
      dmem_ready   = $urandom_range(0, 99) < 55;
      #1;
      evaluate();
      @(posedge clk);
      if (!rst) advance();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Sequencer for the 5-stage RV32I pipeline. It tracks destination-register tags of the in-flight instructions in EX, MEM and WB. From those tags it drives the pipeline-register enables and flushes, and the EX-stage operand forwarding selects. It consumes the decoded control bits that the control unit produces in ID, branch/jump redirects from EX, and the data-memory ready handshake.

Parameters:
REG_ADDR_WIDTH, 5, register index width (x0..x31)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
id_valid  in  1  ID holds a real instruction
id_rs1  in  REG_ADDR_WIDTH  source 1 index of ID instruction
id_rs2  in  REG_ADDR_WIDTH  source 2 index of ID instruction
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
id_rd  in  REG_ADDR_WIDTH  destination index of ID instruction
id_rf_write  in  1  ID instruction writes RF
id_mem_read  in  1  ID instruction is a load
id_mem_write  in  1  ID instruction is a store
ex_redirect  in  1  EX instruction is a taken branch, JAL or JALR
dmem_ready  in  1  DMEM completes the access presented by MEM this cycle
pc_en  out  1  PC register load enable
if_id_en  out  1  IF/ID enable
id_ex_en  out  1  ID/EX enable
ex_mem_en  out  1  EX/MEM enable
if_id_flush  out  1  load bubble into IF/ID
id_ex_flush  out  1  load bubble into ID/EX
mem_wb_flush  out  1  load bubble into MEM/WB
fwd_a_sel  out  2  EX operand A source: 00 RF, 01 EX/MEM, 10 MEM/WB
fwd_b_sel  out  2  EX operand B source, same encoding
stalled  out  1  any stall condition active this cycle

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous, active-high.
- Tags. ex_tag holds {valid, rd, rs1, rs2, uses_rs1, uses_rs2, rf_write, mem_read}. mem_tag holds {valid, rd, rf_write, mem_read, mem_access}. wb_tag holds {valid, rd, rf_write}.
- A writer matches a source only if: tag valid, rf_write=1, rd!=0, rd equals that source index.
- FSM states: BOOT, RUN, MEM_WAIT.
  - rst high: state=BOOT, all tags invalid.
  - BOOT lasts exactly 1 cycle after rst falls, then goes to RUN.
- In BOOT: all enables=0; if_id_flush, id_ex_flush and mem_wb_flush=1; fwd sels=00; stalled=1. These are also the reset values of every output.
- mem_stall = mem_tag.valid & mem_tag.mem_access & ~dmem_ready.
  - RUN goes to MEM_WAIT when mem_stall=1.
  - MEM_WAIT goes back to RUN in the cycle after dmem_ready=1.
  - While mem_stall=1: pc_en, if_id_en, id_ex_en and ex_mem_en=0; mem_wb_flush=1; ex_tag and mem_tag hold; wb_tag becomes invalid.
  - The cycle with dmem_ready=1 advances normally.
- redirect = ex_redirect & ex_tag.valid & ~mem_stall.
  - Effect: pc_en=1, if_id_flush=1, id_ex_flush=1. The branch itself advances into MEM.
  - Redirect overrides any hazard stall in the same cycle, because the ID instruction is squashed.
- hazard = id_valid & (id_uses_rs1 matches | id_uses_rs2 matches) against the set defined under the optional feature.
  - When hazard & ~redirect & ~mem_stall: pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=1.
- Normal advance (no stall): all enables=1, all flushes=0.
- Tag update when ~mem_stall:
  - wb_tag <= mem_tag.
  - mem_tag <= ex_tag, with mem_access = mem_read|mem_write captured from ID.
  - ex_tag <= invalid if redirect, hazard or ~id_valid; otherwise ex_tag <= ID fields.
- Forwarding is combinational from registered tags and applies per operand, independently:
  - 01 if mem_tag matches and mem_tag is not a load.
  - Otherwise 10 if wb_tag matches.
  - Otherwise 00.
  - MEM has priority over WB.
- Priority order: BOOT > mem_stall > redirect > hazard > advance.
- stalled = BOOT | mem_stall | (hazard & ~redirect).
- rst asserted mid-stall: immediate return to BOOT. No tag survives.

Optional Feature:
FORWARDING_EN.
- Defined:
  - Hazard set is ex_tag only, and only when ex_tag.mem_read=1 (load-use). This gives a 1-cycle bubble per load-use.
  - Forwarding selects behave as specified above.
- Undefined:
  - Hazard set is ex_tag, mem_tag and wb_tag for any writer.
  - fwd_a_sel and fwd_b_sel are constant 00.
  - A dependent instruction stalls until its producer has left WB: up to 3 bubbles.

Test Plan:
1. lw x5 then add x6,x5,x7 with FORWARDING_EN defined -> one cycle with pc_en=0, id_ex_flush=1; then add in EX with fwd_a_sel=10, fwd_b_sel=00.
2. add x3,x1,x2 then sub x4,x3,x3 -> no stall; fwd_a_sel=01 and fwd_b_sel=01. With FORWARDING_EN undefined -> 3 stall cycles, sels 00.
3. Producer writes x0, followed by consumer of x0 -> never stalls; sels stay 00.
4. Store in MEM with dmem_ready low for 3 cycles -> state MEM_WAIT; enables 0 and mem_wb_flush=1 for exactly 3 cycles; resumes on the ready cycle.
5. ex_redirect=1 while ID holds a load-use consumer -> if_id_flush=1, id_ex_flush=1, pc_en=1, no hazard stall; ex_tag invalid next cycle.
6. rst pulsed during MEM_WAIT -> outputs immediately at reset values; one BOOT cycle after release; first ID instruction sees sels 00 and no stall.
